// File: rtl/uart_byte_rx_pkg.sv
// Shared constants and FSM encoding for the host UART receiver and the
// other blocks clocked from the 128 MHz PLL output.
package uart_byte_rx_pkg;

   localparam int unsigned SYS_CLK_HZ = 128000000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_byte_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the flops
// come out of reset holding RST_VAL.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // rst is active-low
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 serial receiver: start-bit qualify at half bit, mid-bit sampling,
// valid/ready output with frame-error and overrun pulses.
module uart_byte_rx
   import uart_byte_rx_pkg::*;
#(
   parameter int unsigned CLK_HZ = SYS_CLK_HZ,
   parameter int unsigned BAUD   = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("uart_byte_rx: CLK_HZ/BAUD must be at least 4");
   end

   rx_state_t        state, state_nxt;
   logic             rx_s;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       index;
   logic [7:0]       shift_reg;
   logic             tick, load_half, load_bit, shift_en, byte_done, stop_bad;

   sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   assign tick = (cnt == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_half = 1'b0;
      load_bit  = 1'b0;
      shift_en  = 1'b0;
      byte_done = 1'b0;
      stop_bad  = 1'b0;
      unique case (state)
         IDLE: if (!rx_s) begin
            state_nxt = START;
            load_half = 1'b1;
         end
         START: if (tick) begin
            // a start bit that is already high again at mid-bit was noise
            if (rx_s) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = DATA;
               load_bit  = 1'b1;
            end
         end
         DATA: if (tick) begin
            shift_en = 1'b1;
            load_bit = 1'b1;
            if (index == 3'd7) state_nxt = STOP;
         end
         STOP: if (tick) begin
            if (rx_s) begin
               byte_done = 1'b1;
               state_nxt = IDLE;
            end else begin
               stop_bad  = 1'b1;
               state_nxt = BREAK;
            end
         end
         BREAK: if (rx_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= '0;
         index <= '0;
      end else begin
         if (load_half)        cnt <= HALF_LOAD;
         else if (load_bit)    cnt <= BIT_LOAD;
         else if (cnt != '0)   cnt <= cnt - 1'b1;

         if (load_half)        index <= '0;
         else if (shift_en)    index <= index + 3'd1;
      end
   end

   // shift register only feeds data on byte_done, so it needs no reset
   always_ff @(posedge clk) begin
      if (shift_en) shift_reg[index] <= rx_s;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         overrun   <= 1'b0;
         if (byte_done && (!valid || ready)) begin
            data  <= shift_reg;
            valid <= 1'b1;
         end else if (byte_done) begin
            overrun <= 1'b1;
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Host-to-FPGA serial receiver for the SDR transmit chain. Deserializes 8N1 asynchronous serial data on `rx` in the 128 MHz PLL clock domain. Presents each received byte on a valid/ready interface to the downstream sample/control path. It is the receiving end of the host's UART link; framing errors and overruns are flagged, never silently merged into data.

## Interface

Parameters:
- `CLK_HZ`, 128000000, frequency of `clk` in Hz
- `BAUD`, 115200, line rate in bit/s
- derived localparam `CLKS_PER_BIT` = `CLK_HZ/BAUD` (integer division; 1111 at defaults); `HALF_BIT` = `CLKS_PER_BIT/2`; elaboration must fail if `CLKS_PER_BIT` < 4

Ports:
- `clk`, in, 1, system clock (PLL output)
- `rst`, in, 1, asynchronous, active-low reset
- `rx`, in, 1, serial line, idle high, asynchronous to `clk`
- `data`, out, 8, received byte, LSB first on the line
- `valid`, out, 1, `data` holds an unconsumed byte
- `ready`, in, 1, consumer accepts `data` when `valid && ready` at a rising edge
- `frame_err`, out, 1, one-cycle pulse: stop bit sampled low
- `overrun`, out, 1, one-cycle pulse: byte completed while previous still unconsumed

## Operation

- `rx` passes through a 2-flop synchronizer (flops reset to 1); all logic uses the synchronized `rx_s`.
- Reset values: `data`=0, `valid`=0, `frame_err`=0, `overrun`=0, FSM=IDLE, bit counter=0, baud counter=0.
- FSM states and transitions:
  - IDLE: `rx_s`=0 -> START, load baud counter.
  - START: after `HALF_BIT` cycles sample `rx_s`; 0 -> DATA (bit index 0); 1 -> IDLE (glitch rejected, no flags).
  - DATA: every `CLKS_PER_BIT` cycles shift `rx_s` into bit position `index`; after bit 7 -> STOP.
  - STOP: after `CLKS_PER_BIT` cycles sample; 1 -> byte complete, IDLE; 0 -> `frame_err` pulse, byte discarded, BREAK.
  - BREAK: wait for `rx_s`=1, then IDLE (prevents a held-low line retriggering).
- Byte complete with `valid`=0, or with `valid && ready` in the same cycle: load `data`, `valid`=1.
- Byte complete with `valid`=1 and `ready`=0: new byte dropped, `data` unchanged, `overrun` pulses one cycle.
- `valid` falls the cycle after `valid && ready` unless a new byte loads in that same cycle. `ready` is ignored while `valid`=0.
- `rst` asserted mid-frame: frame abandoned, all outputs to reset values immediately; no partial byte is ever presented.

## Timing

- Cycle 0 = first rising edge where `rx_s`=0 in IDLE; `rx_s` lags the pin by 2 cycles.
- Start sample at cycle `HALF_BIT`; data bit i (0..7) at `HALF_BIT + (i+1)*CLKS_PER_BIT`; stop at `HALF_BIT + 9*CLKS_PER_BIT`.
- `valid` (or `frame_err`/`overrun`) asserted from cycle `HALF_BIT + 9*CLKS_PER_BIT + 1`.
- FSM is in IDLE the cycle after the stop sample, so back-to-back frames with a single stop bit are received without loss.
- Baud counter width `$clog2(CLKS_PER_BIT)`; counts down, reloads on each sample; never wraps unloaded.

## Structure

- Shared package/header: FSM state encoding (IDLE, START, DATA, STOP, BREAK) and the system clock constant 128000000, also used by the counter/blinky blocks.
- One sub-module: `sync_2ff` (parameterized reset value, default 1), reused for other asynchronous inputs.
- Rest is flat: FSM, baud counter, 3-bit index, shift register, output register.

## Test plan

All tests use `CLK_HZ`=1600000, `BAUD`=100000 (`CLKS_PER_BIT`=16, `HALF_BIT`=8).
- Reset: hold `rst`=0 with `rx` toggling -> `data`=0x00, `valid`=0, no pulses; release -> IDLE.
- Send 0xA5, `ready`=1 -> `valid` high exactly at cycle 8+144+1=153 after `rx_s` falls, `data`=0xA5, single-cycle `valid`.
- Send 0x3C then 0xC3 back-to-back, `ready`=0 -> `data`=0x3C held, `overrun` pulses once at second byte end; assert `ready` -> 0x3C consumed, `valid` falls.
- Send 0x55 with stop bit 0, then hold `rx` low 40 cycles -> `frame_err` one pulse, `valid` stays 0, no new frame until `rx` returns high; next 0x0F received correctly.
- Glitch: `rx` low for 4 cycles -> no `valid`, no flags, FSM back in IDLE by cycle 9.
- Assert `rst` during DATA bit 3 of 0xFF, release, send 0x81 -> only 0x81 delivered.
